// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared constants for the seven-segment scanner.
// Holds the hex-to-segment patterns, the blank pattern and the segment bit order
// of seg_data = {dp,g,f,e,d,c,b,a}.
package seg_disp_pkg;

    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam int SEG_BIT_A  = 0;
    localparam int SEG_BIT_G  = 6;
    localparam int SEG_BIT_DP = 7;

    // Entry n is the {g,f,e,d,c,b,a} pattern for hex digit n.
    localparam logic [15:0][6:0] HEX7_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        return HEX7_LUT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: valid/ready image-update channel into the display scanner.
// The master offers a whole display image; the slave (scanner) accepts it.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    upd_valid;
    logic                    upd_ready;
    logic [4*NUM_DIGITS-1:0] upd_value;
    logic [NUM_DIGITS-1:0]   upd_dp;
    logic [NUM_DIGITS-1:0]   upd_blank;
    logic [NUM_DIGITS-1:0]   upd_blink;

    modport master (
        output upd_valid, upd_value, upd_dp, upd_blank, upd_blink,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_value, upd_dp, upd_blank, upd_blink,
        output upd_ready
    );

endinterface

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: one digit worth of segment generation.
// A dark digit is fully off, decimal point included.
module seg_hex_decoder
    import seg_disp_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    // Map nibble + dp to segments unless the digit is forced dark.
    always_comb begin
        seg = SEG_OFF;
        if (!dark) begin
            seg[SEG_BIT_DP]          = dp;
            seg[SEG_BIT_G:SEG_BIT_A] = hex7(value);
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment scanner with its own scan tick,
// blink timebase and a frame-synchronous (tear-free) image update handshake.
// Optional build macro LZ_SUPPRESS_EN enables leading-zero suppression.
module seg_scan_display
    import seg_disp_pkg::*;
#(
    parameter  int NUM_DIGITS   = 8,
    parameter  int SCAN_DIV     = 50000,
    parameter  int BLINK_FRAMES = 125,
    localparam int DIGIT_W      = $clog2(NUM_DIGITS)
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_display_if.slave  upd,
    output logic [DIGIT_W-1:0] digit,
    output logic [7:0]         seg_data,
    output logic               frame_done
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             wrap_tick;

    logic [4*NUM_DIGITS-1:0] act_value, pend_value;
    logic [NUM_DIGITS-1:0]   act_dp,    pend_dp;
    logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
    logic [NUM_DIGITS-1:0]   act_blink, pend_blink;
    logic                    pend_full;
    logic                    capture;
    logic                    commit;

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             blink_phase_p0;

    // Image, digit and phase that will be on the pins after the next tick.
    logic [4*NUM_DIGITS-1:0] img_value_p0;
    logic [NUM_DIGITS-1:0]   img_dp_p0;
    logic [NUM_DIGITS-1:0]   img_blank_p0;
    logic [NUM_DIGITS-1:0]   img_blink_p0;
    logic [NUM_DIGITS-1:0]   lz_mask_p0;
    logic [NUM_DIGITS-1:0]   dark_p0;
    logic [DIGIT_W-1:0]      digit_p0;
    logic [3:0]              sel_value_p0;
    logic                    sel_dp_p0;
    logic                    sel_dark_p0;
    logic [7:0]              seg_p0;

    assign tick      = (pre_cnt == PRE_W'(SCAN_DIV - 1));
    assign wrap_tick = tick && (digit == DIGIT_W'(NUM_DIGITS - 1));

    // A new image can only be taken while the pending buffer is empty, so a
    // capture never coincides with a commit of the same buffer.
    assign capture       = upd.upd_valid && upd.upd_ready;
    assign commit        = wrap_tick && pend_full;
    assign upd.upd_ready = !pend_full;

    // Prescaler: free-running 0..SCAN_DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else pre_cnt <= pre_cnt + PRE_W'(1);
    end

    // Pending buffer: holds an accepted image until the next frame wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_full  <= 1'b0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_blink <= '0;
        end else if (capture) begin
            pend_full  <= 1'b1;
            pend_value <= upd.upd_value;
            pend_dp    <= upd.upd_dp;
            pend_blank <= upd.upd_blank;
            pend_blink <= upd.upd_blink;
        end else if (commit) begin
            pend_full  <= 1'b0;
        end
    end

    // Active image: swapped only at a frame wrap so a frame is never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            act_blink <= '0;
        end else if (commit) begin
            act_value <= pend_value;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
            act_blink <= pend_blink;
        end
    end

    // Blink timebase: the phase flips every BLINK_FRAMES frame wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap_tick) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= blink_phase_p0;
            end else begin
                blink_cnt   <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // ---- stage p0: next digit, next image, next phase ----
    assign blink_phase_p0 = !blink_phase;

    always_comb begin
        img_value_p0 = commit ? pend_value : act_value;
        img_dp_p0    = commit ? pend_dp    : act_dp;
        img_blank_p0 = commit ? pend_blank : act_blank;
        img_blink_p0 = commit ? pend_blink : act_blink;
        digit_p0     = (digit == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit + DIGIT_W'(1);
    end

`ifdef LZ_SUPPRESS_EN
    // Blank zero digits from the top down until a nonzero value or a set dp.
    function automatic logic [NUM_DIGITS-1:0] lz_mask_f(
        input logic [4*NUM_DIGITS-1:0] val,
        input logic [NUM_DIGITS-1:0]   dps
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (run && (val[4*i +: 4] == 4'd0) && !dps[i]) m[i] = 1'b1;
            else run = 1'b0;
        end
        return m;
    endfunction

    assign lz_mask_p0 = lz_mask_f(img_value_p0, img_dp_p0);
`else
    assign lz_mask_p0 = '0;
`endif

    // Blink uses the phase valid for the frame the next digit belongs to.
    always_comb begin
        dark_p0      = img_blank_p0 | lz_mask_p0
                     | (img_blink_p0 & {NUM_DIGITS{wrap_tick ? (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) ^ blink_phase
                                                             : blink_phase}});
        sel_value_p0 = img_value_p0[{digit_p0, 2'b00} +: 4];
        sel_dp_p0    = img_dp_p0[digit_p0];
        sel_dark_p0  = dark_p0[digit_p0];
    end

    seg_hex_decoder u_dec (
        .value (sel_value_p0),
        .dp    (sel_dp_p0),
        .dark  (sel_dark_p0),
        .seg   (seg_p0)
    );

    // ---- stage p1: registered digit select, segments and frame pulse ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit      <= '0;
            seg_data   <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_tick;
            if (tick) begin
                digit    <= digit_p0;
                seg_data <= seg_p0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed bench for seg_scan_display with
// NUM_DIGITS=8, SCAN_DIV=4, BLINK_FRAMES=2. Honours LZ_SUPPRESS_EN.
module tb_seg_scan_display;

    localparam int ND = 8;

    logic       clk;
    logic       reset;
    logic [2:0] digit;
    logic [7:0] seg_data;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_display_if #(.NUM_DIGITS(ND)) upd_if ();

    seg_scan_display #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd_if),
        .digit      (digit),
        .seg_data   (seg_data),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next frame_done pulse (bounded).
    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        chk("frame_wait", frame_done, 1'b1);
    endtask

    // Offer one image for a single cycle at the current negedge.
    task automatic offer(input logic [31:0] v, input logic [7:0] dp,
                         input logic [7:0] blank, input logic [7:0] blink);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_value = v;
        upd_if.upd_dp    = dp;
        upd_if.upd_blank = blank;
        upd_if.upd_blink = blink;
        step(1);
        upd_if.upd_valid = 1'b0;
    endtask

    // Starting in a frame_done cycle, check all eight slots of one frame.
    // exp[8d+7:8d] is the pattern expected on digit d.
    task automatic check_frame(input string tag, input logic [63:0] exp);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s digit%0d", tag, d), digit, d);
            chk($sformatf("%s seg%0d", tag, d), seg_data, exp[8*d +: 8]);
            chk($sformatf("%s fdone%0d", tag, d), frame_done, (d == 0));
            step(4);
        end
    endtask

    localparam logic [63:0] IMG_ZERO = 64'h0;
    localparam logic [63:0] IMG_A    = 64'h077D6D664F5B063F;
    localparam logic [63:0] IMG_B    = 64'h71795E397C776F7F;
    localparam logic [7:0]  BLINK_EXP [4] = '{8'h00, 8'h7F, 8'h7F, 8'h00};

    initial begin
        logic [63:0] exp_a;
        exp_a = IMG_A;

        reset            = 1'b1;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_value = '0;
        upd_if.upd_dp    = '0;
        upd_if.upd_blank = '0;
        upd_if.upd_blink = '0;
        step(2);

        // Reset state
        chk("rst digit", digit, 0);
        chk("rst seg", seg_data, 8'h00);
        chk("rst ready", upd_if.upd_ready, 1'b1);
        chk("rst fdone", frame_done, 1'b0);
        reset = 1'b0;

        // No image loaded: whole frame dark
        wait_frame();
        check_frame("dark", IMG_ZERO);

        // Load 76543210 and see it after the next wrap
        offer(32'h76543210, 8'h00, 8'h00, 8'h00);
        chk("A ready low", upd_if.upd_ready, 1'b0);
        wait_frame();
        chk("A ready back", upd_if.upd_ready, 1'b1);
        check_frame("A", IMG_A);

        // Mid-frame offer of FEDCBA98 while A is showing
        step(12);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_value = 32'hFEDCBA98;
        upd_if.upd_dp    = '0;
        upd_if.upd_blank = '0;
        upd_if.upd_blink = '0;
        step(1);
        chk("B ready low", upd_if.upd_ready, 1'b0);
        upd_if.upd_value = 32'h11111111;
        step(3);
        upd_if.upd_valid = 1'b0;
        for (int d = 4; d < ND; d++) begin
            chk($sformatf("B old seg%0d", d), seg_data, exp_a[8*d +: 8]);
            chk($sformatf("B ready%0d", d), upd_if.upd_ready, 1'b0);
            step(4);
        end
        chk("B ready back", upd_if.upd_ready, 1'b1);
        check_frame("B", IMG_B);

        // Capture in the wrap cycle: commit deferred one frame
        step(31);
        chk("C pre digit", digit, 7);
        offer(32'h33333333, 8'h00, 8'h00, 8'h00);
        chk("C wrap fdone", frame_done, 1'b1);
        chk("C wrap seg", seg_data, 8'h7F);
        chk("C wrap ready", upd_if.upd_ready, 1'b0);
        step(28);
        chk("C d7 seg", seg_data, 8'h71);
        chk("C d7 ready", upd_if.upd_ready, 1'b0);
        step(4);
        chk("C commit fdone", frame_done, 1'b1);
        chk("C commit seg", seg_data, 8'h4F);
        chk("C commit ready", upd_if.upd_ready, 1'b1);

        // Reset mid-frame with an image pending
        step(8);
        chk("E pre seg", seg_data, 8'h4F);
        offer(32'h88888888, 8'h00, 8'h00, 8'h00);
        chk("E ready low", upd_if.upd_ready, 1'b0);
        step(2);
        reset = 1'b1;
        #1;
        chk("mid rst digit", digit, 0);
        chk("mid rst seg", seg_data, 8'h00);
        chk("mid rst ready", upd_if.upd_ready, 1'b1);
        chk("mid rst fdone", frame_done, 1'b0);
        step(2);
        reset = 1'b0;
        wait_frame();
        check_frame("post rst", IMG_ZERO);

        // Blink on digit 0 (value 8), dp on digit 1 (value 1)
        offer(32'h00000018, 8'h02, 8'h00, 8'h01);
        wait_frame();
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("blink d0 f%0d", f), seg_data, BLINK_EXP[f]);
            step(4);
            chk($sformatf("dp d1 f%0d", f), seg_data, 8'h86);
            step(28);
        end

`ifdef LZ_SUPPRESS_EN
        // Leading-zero suppression
        offer(32'h00000090, 8'h00, 8'h00, 8'h00);
        wait_frame();
        check_frame("lz 90", 64'h0000000000006F3F);
        offer(32'h00000000, 8'h00, 8'h00, 8'h00);
        wait_frame();
        check_frame("lz 0", 64'h000000000000003F);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
